// File: rtl/regfile_mp.sv
// regfile_mp: two-write / two-read register file with registered reads,
// optional same-edge write-to-read bypass, optional hardwired zero entry
// (highest address) and a sequenced bulk-clear engine that zeroes one
// entry per cycle while reads and writes continue.
module regfile_mp #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_register1,
  input  logic [ADDR_WIDTH-1:0] read_register2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  input  logic                  reg_write,
  input  logic [ADDR_WIDTH-1:0] write_register,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reg_write_b,
  input  logic [ADDR_WIDTH-1:0] write_register_b,
  input  logic [DATA_WIDTH-1:0] write_data_b,
  input  logic                  clear_req,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  we_a;
  logic                  we_b;
  logic [DATA_WIDTH-1:0] rd1_next;
  logic [DATA_WIDTH-1:0] rd2_next;

  // Value a read port captures at this edge: old contents, overridden by the
  // zero entry, then port B, then port A, then the entry being cleared.
  function automatic logic [DATA_WIDTH-1:0] read_value(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] old
  );
    logic [DATA_WIDTH-1:0] v;
    v = old;
    if ((ZERO_REG != 0) && (addr == LAST)) begin
      v = '0;
    end else if ((BYPASS != 0) && reg_write_b && (write_register_b == addr)) begin
      v = write_data_b;
    end else if ((BYPASS != 0) && reg_write && (write_register == addr)) begin
      v = write_data;
    end else if ((BYPASS != 0) && (state == CLEAR) && (ptr == addr)) begin
      v = '0;
    end else begin
      v = old;
    end
    return v;
  endfunction

  // Writes aimed at the hardwired zero entry are dropped at the source.
  assign we_a = reg_write   && !((ZERO_REG != 0) && (write_register   == LAST));
  assign we_b = reg_write_b && !((ZERO_REG != 0) && (write_register_b == LAST));

  // Next read-port values, resolved before the edge from current contents.
  always_comb begin
    rd1_next = read_value(read_register1, mem[read_register1]);
    rd2_next = read_value(read_register2, mem[read_register2]);
  end

  // Storage array: clear pointer beats port B, port B beats port A.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((state == CLEAR) && (ptr == ADDR_WIDTH'(i))) begin
          mem[i] <= '0;
        end else if (we_b && (write_register_b == ADDR_WIDTH'(i))) begin
          mem[i] <= write_data_b;
        end else if (we_a && (write_register == ADDR_WIDTH'(i))) begin
          mem[i] <= write_data;
        end else begin
          mem[i] <= mem[i];
        end
      end
    end
  end

  // Registered read ports.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data1 <= '0;
      read_data2 <= '0;
    end else begin
      read_data1 <= rd1_next;
      read_data2 <= rd2_next;
    end
  end

  // Bulk-clear sequencer: one entry per edge, busy for exactly DEPTH cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_req) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            ptr   <= ptr;
            busy  <= 1'b0;
          end
        end
        CLEAR: begin
          ptr <= ptr + ADDR_WIDTH'(1);
          if (ptr == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= CLEAR;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ptr   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: drives a bypassing and a non-bypassing regfile_mp with the
// same stimulus; checks a directed vector table, clear/reset sequences and a
// random phase against an array-based reference model.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ra1, ra2, wa, wab;
  logic [63:0] wd, wdb;
  logic        we, web, clr;
  logic [63:0] rd1, rd2, nrd1, nrd2;
  logic        busy, nbusy;

  int n_vec = 0;
  int n_err = 0;

  // reference model: plain array plus "clear in progress" bookkeeping
  logic [63:0] mdl [32];
  bit          clr_on;
  int          clr_idx;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .reset(reset),
    .read_register1(ra1), .read_register2(ra2),
    .read_data1(rd1), .read_data2(rd2),
    .reg_write(we), .write_register(wa), .write_data(wd),
    .reg_write_b(web), .write_register_b(wab), .write_data_b(wdb),
    .clear_req(clr), .busy(busy));

  regfile_mp #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset),
    .read_register1(ra1), .read_register2(ra2),
    .read_data1(nrd1), .read_data2(nrd2),
    .reg_write(we), .write_register(wa), .write_data(wd),
    .reg_write_b(web), .write_register_b(wab), .write_data_b(wdb),
    .clear_req(clr), .busy(nbusy));

  typedef struct {
    logic        we;  logic [4:0] wa;  logic [63:0] wd;
    logic        web; logic [4:0] wab; logic [63:0] wdb;
    logic [4:0]  ra1; logic [4:0] ra2;
    logic [63:0] e1;  logic [63:0] e2;    // bypassing instance
    logic [63:0] n1;  logic [63:0] n2;    // non-bypassing instance
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pred(input logic [4:0] a, input bit byp);
    if (a == 5'd31) return 64'h0;
    if (byp && web && wab == a) return wdb;
    if (byp && we && wa == a) return wd;
    if (byp && clr_on && clr_idx == int'(a)) return 64'h0;
    return mdl[a];
  endfunction

  task automatic idle_inputs();
    we = 1'b0; web = 1'b0; clr = 1'b0;
    wa = 5'd0; wab = 5'd0; wd = 64'h0; wdb = 64'h0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = 64'h0;
    clr_on = 1'b0; clr_idx = 0;
  endtask

  // one clock edge: predict, advance the model, then compare if asked
  task automatic tick(input bit do_chk);
    logic [63:0] e1, e2, n1, n2;
    e1 = pred(ra1, 1'b1); e2 = pred(ra2, 1'b1);
    n1 = pred(ra1, 1'b0); n2 = pred(ra2, 1'b0);
    if (we && wa != 5'd31) mdl[wa] = wd;
    if (web && wab != 5'd31) mdl[wab] = wdb;
    if (clr_on) begin
      mdl[clr_idx] = 64'h0;
      clr_idx++;
      if (clr_idx == 32) clr_on = 1'b0;
    end else if (clr) begin
      clr_on = 1'b1; clr_idx = 0;
    end
    @(posedge clk); #1;
    if (do_chk) begin
      chk("rd1", rd1, e1);   chk("rd2", rd2, e2);
      chk("nb_rd1", nrd1, n1); chk("nb_rd2", nrd2, n2);
      chk("busy", {63'h0, busy}, {63'h0, clr_on});
      chk("nb_busy", {63'h0, nbusy}, {63'h0, clr_on});
    end
  endtask

  initial begin
    int busy_cnt;
    tbl[0]  = '{1'b1, 5'd3, 64'h1234, 1'b0, 5'd0, 64'h0,  5'd3,  5'd3,  64'h1234, 64'h1234, 64'h0, 64'h0};
    tbl[1]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,  5'd3,  5'd0,  64'h1234, 64'h0,    64'h1234, 64'h0};
    tbl[2]  = '{1'b1, 5'd5, 64'h11,   1'b0, 5'd0, 64'h0,  5'd5,  5'd5,  64'h11,   64'h11,   64'h0, 64'h0};
    tbl[3]  = '{1'b1, 5'd5, 64'hAA,   1'b1, 5'd5, 64'hBB, 5'd5,  5'd5,  64'hBB,   64'hBB,   64'h11, 64'h11};
    tbl[4]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,  5'd5,  5'd5,  64'hBB,   64'hBB,   64'hBB, 64'hBB};
    tbl[5]  = '{1'b1, 5'd31, 64'hFFFF, 1'b0, 5'd0, 64'h0, 5'd31, 5'd31, 64'h0,    64'h0,    64'h0, 64'h0};
    tbl[6]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,  5'd31, 5'd3,  64'h0,    64'h1234, 64'h0, 64'h1234};
    tbl[7]  = '{1'b1, 5'd8, 64'h88,   1'b1, 5'd7, 64'h77, 5'd7,  5'd8,  64'h77,   64'h88,   64'h0, 64'h0};
    tbl[8]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,  5'd8,  5'd7,  64'h88,   64'h77,   64'h88, 64'h77};
    tbl[9]  = '{1'b1, 5'd9, 64'h99,   1'b1, 5'd31, 64'hDEAD, 5'd31, 5'd9, 64'h0,    64'h99,   64'h0, 64'h0};
    tbl[10] = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,  5'd9,  5'd31, 64'h99,   64'h0,    64'h99, 64'h0};

    // reset state
    reset = 1'b1; ra1 = 5'd0; ra2 = 5'd0; idle_inputs(); model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("reset_rd1", rd1, 64'h0); chk("reset_rd2", rd2, 64'h0);
    chk("reset_busy", {63'h0, busy}, 64'h0);
    reset = 1'b0;

    // directed vector table
    for (int i = 0; i < 11; i++) begin
      we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd;
      web = tbl[i].web; wab = tbl[i].wab; wdb = tbl[i].wdb;
      ra1 = tbl[i].ra1; ra2 = tbl[i].ra2;
      tick(1'b0);
      chk($sformatf("tbl%0d_rd1", i), rd1, tbl[i].e1);
      chk($sformatf("tbl%0d_rd2", i), rd2, tbl[i].e2);
      chk($sformatf("tbl%0d_nb_rd1", i), nrd1, tbl[i].n1);
      chk($sformatf("tbl%0d_nb_rd2", i), nrd2, tbl[i].n2);
    end
    idle_inputs();

    // bulk clear: load r0..r30 with i+1, pulse clear, write r2 at pointer 20
    for (int i = 0; i < 31; i++) begin
      we = 1'b1; wa = 5'(i); wd = 64'(i + 1); ra1 = 5'(i); ra2 = 5'd30;
      tick(1'b1);
    end
    idle_inputs(); clr = 1'b1;
    tick(1'b1);
    clr = 1'b0;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    for (int k = 0; k < 40; k++) begin
      idle_inputs();
      if (k == 20) begin we = 1'b1; wa = 5'd2; wd = 64'h77; end
      if (k == 5) clr = 1'b1;   // ignored while busy
      ra1 = 5'($urandom_range(0, 31)); ra2 = 5'(k % 32);
      tick(1'b1);
      if (busy === 1'b1) busy_cnt++;
    end
    idle_inputs();
    chk("clear_busy_cycles", 64'(busy_cnt), 64'd32);
    for (int i = 0; i < 32; i += 2) begin
      ra1 = 5'(i); ra2 = 5'(i + 1);
      tick(1'b1);
      chk($sformatf("clr_r%0d", i), rd1, (i == 2) ? 64'h77 : 64'h0);
      chk($sformatf("clr_r%0d", i + 1), rd2, 64'h0);
    end

    // reset in the middle of a clear, pointer at 10
    for (int i = 0; i < 31; i++) begin
      we = 1'b1; wa = 5'(i); wd = 64'hA000 + 64'(i); tick(1'b0);
    end
    idle_inputs(); clr = 1'b1; tick(1'b1); clr = 1'b0;
    for (int k = 0; k < 10; k++) tick(1'b1);
    reset = 1'b1; #2;
    chk("midclr_busy", {63'h0, busy}, 64'h0);
    chk("midclr_rd1", rd1, 64'h0);
    chk("midclr_nb_rd2", nrd2, 64'h0);
    model_reset();
    @(posedge clk); #1; reset = 1'b0;
    for (int i = 0; i < 32; i += 2) begin
      ra1 = 5'(i); ra2 = 5'(i + 1);
      tick(1'b1);
      chk($sformatf("rst_r%0d", i), rd1, 64'h0);
      chk($sformatf("rst_r%0d", i + 1), nrd2, 64'h0);
    end

    // random phase against the model
    for (int k = 0; k < 400; k++) begin
      we  = 1'($urandom_range(0, 1)); wa  = 5'($urandom); wd  = {$urandom, $urandom};
      web = 1'($urandom_range(0, 1)); wab = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      wdb = {$urandom, $urandom};
      ra1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
      ra2 = ($urandom_range(0, 2) == 0) ? wab : 5'($urandom);
      clr = ($urandom_range(0, 59) == 0);
      tick(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
